// File: rtl/display_pkg.sv
// Shared display constants and helpers for the LED
// matrix scanner and the digit multiplexer.
package display_pkg;

  localparam int ROWS = 8;
  localparam int SCAN_DIV_DEFAULT = 2500;

  localparam logic [7:0] ROW_OFF = 8'hFF;
  localparam logic [7:0] COL_OFF = 8'h00;

  typedef enum logic {
    IDLE,
    PENDING
  } commit_state_t;

  // Active-low one-hot: row r pulls bit (7-r) low.
  function automatic logic [7:0] row_sel(
    input logic [2:0] idx
  );
    return ~(8'b1000_0000 >> idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV
// clk_in cycles, first tick on the SCAN_DIV-th edge.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk_in,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Double-buffered 8x8 LED matrix scanner; the back
// buffer is published only at a frame boundary.
module dot_matrix_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       busy,
  output logic [7:0] dot_row,
  output logic [7:0] dot_col,
  output logic       frame_start
);

  logic          tick;
  logic [2:0]    ptr;
  logic          sel;
  logic          back;
  logic          front;
  logic          swap;
  logic          wr_ok;
  commit_state_t state;
  commit_state_t state_nxt;

  logic [7:0] bufs [2][ROWS];

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk_in(clk_in),
    .reset (reset),
    .tick  (tick)
  );

  assign busy  = (state == PENDING);
  assign wr_ok = wr_en & ~busy;
  assign back  = ~sel;
  assign swap  = tick & (ptr == 3'd0) & busy;
  // Row 0 of the swap tick already reads the new front.
  assign front = swap ? ~sel : sel;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (commit) state_nxt = PENDING;
      PENDING: if (swap)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bufs[b][r] <= '0;
        end
      end
    end else if (wr_ok) begin
      bufs[back][wr_row] <= wr_data;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      sel         <= 1'b0;
      dot_row     <= ROW_OFF;
      dot_col     <= COL_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        dot_row     <= row_sel(ptr);
        dot_col     <= bufs[front][ptr];
        frame_start <= (ptr == 3'd0);
        ptr         <= ptr + 3'd1;
        if (swap) begin
          sel <= ~sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner with a
// 4-cycle scan tick.
module tb_dot_matrix_scanner;

  localparam int DIV = 4;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       wr_en  = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       commit = 1'b0;
  logic       busy;
  logic [7:0] dot_row;
  logic [7:0] dot_col;
  logic       frame_start;

  dot_matrix_scanner #(
    .SCAN_DIV(DIV)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .commit     (commit),
    .busy       (busy),
    .dot_row    (dot_row),
    .dot_col    (dot_col),
    .frame_start(frame_start)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         frame;
    int         row;
    int         edge_n;
    logic [7:0] dot_row;
    logic [7:0] dot_col;
    logic       fs;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  bit   run = 1'b0;
  logic [7:0] prev_row = 8'hFF;

  logic [7:0] row_tab [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] img     [8] = '{8'h18, 8'h18, 8'h3C, 8'h3C,
                              8'h5A, 8'h18, 8'h18, 8'h24};
  logic [7:0] f_7e    [8] = '{8'h00, 8'h00, 8'h00, 8'h7E,
                              8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] blank   [8] = '{default: 8'h00};

  always @(posedge clk_in or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(string name, logic [7:0] act,
                       logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(int f, logic [7:0] d [8],
                            int nrows);
    exp_t e;
    for (int r = 0; r < nrows; r++) begin
      e.frame   = f;
      e.row     = r;
      e.edge_n  = DIV * (8 * f + r + 1);
      e.dot_row = row_tab[r];
      e.dot_col = d[r];
      e.fs      = (r == 0);
      sb_q.push_back(e);
    end
  endtask

  task automatic at(int n);
    while (cyc < n) @(negedge clk_in);
  endtask

  // Monitor: every change of dot_row marks a scan tick.
  always @(negedge clk_in) begin
    exp_t e;
    if (!run) begin
      prev_row = 8'hFF;
    end else if (dot_row !== prev_row) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL tick: unexpected update at edge %0d row=%h col=%h",
                 cyc, dot_row, dot_col);
      end else begin
        e = sb_q.pop_front();
        if (cyc != e.edge_n || dot_row !== e.dot_row ||
            dot_col !== e.dot_col || frame_start !== e.fs) begin
          errors++;
          $display("FAIL tick f%0d r%0d: got edge=%0d row=%h col=%h fs=%b expected edge=%0d row=%h col=%h fs=%b",
                   e.frame, e.row, cyc, dot_row, dot_col,
                   frame_start, e.edge_n, e.dot_row,
                   e.dot_col, e.fs);
        end
      end
      prev_row = dot_row;
    end else begin
      checks++;
      if (frame_start !== 1'b0) begin
        errors++;
        $display("FAIL fs_idle: got %b expected 0 at edge %0d",
                 frame_start, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_row", dot_row, 8'hFF);
    check("rst_col", dot_col, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_fs", {7'd0, frame_start}, 8'h00);

    push_frame(0, blank, 8);
    push_frame(1, img, 8);
    push_frame(2, f_7e, 8);
    push_frame(3, f_7e, 8);
    push_frame(4, img, 4);

    @(negedge clk_in);
    #2;
    run   = 1'b1;
    reset = 1'b1;

    for (int r = 0; r < 8; r++) begin
      at(r);
      wr_en   = 1'b1;
      wr_row  = 3'(r);
      wr_data = img[r];
    end
    at(8);
    wr_en  = 1'b0;
    commit = 1'b1;
    at(9);
    check("busy_after_commit", {7'd0, busy}, 8'h01);
    wr_en   = 1'b1;
    wr_row  = 3'd2;
    wr_data = 8'hFF;
    commit  = 1'b1;
    at(10);
    wr_en  = 1'b0;
    commit = 1'b0;
    at(35);
    check("busy_before_swap1", {7'd0, busy}, 8'h01);
    at(36);
    check("busy_after_swap1", {7'd0, busy}, 8'h00);

    at(39);
    wr_en   = 1'b1;
    wr_row  = 3'd3;
    wr_data = 8'h7E;
    commit  = 1'b1;
    at(40);
    wr_en  = 1'b0;
    commit = 1'b0;
    check("busy_same_cycle", {7'd0, busy}, 8'h01);
    at(67);
    check("busy_before_swap2", {7'd0, busy}, 8'h01);
    at(68);
    check("busy_after_swap2", {7'd0, busy}, 8'h00);

    // Commit lands on a row-0 tick: swap waits a frame.
    at(99);
    commit = 1'b1;
    at(100);
    commit = 1'b0;
    check("busy_commit_on_tick", {7'd0, busy}, 8'h01);
    at(131);
    check("busy_held_full_frame", {7'd0, busy}, 8'h01);
    at(132);
    check("busy_after_swap3", {7'd0, busy}, 8'h00);

    at(139);
    commit = 1'b1;
    at(140);
    commit = 1'b0;
    check("busy_before_reset", {7'd0, busy}, 8'h01);
    at(145);
    #2;
    run   = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_row", dot_row, 8'hFF);
    check("midrst_col", dot_col, 8'h00);
    check("midrst_busy", {7'd0, busy}, 8'h00);
    check("midrst_fs", {7'd0, frame_start}, 8'h00);
    check("sb_drained1", 8'(sb_q.size()), 8'h00);

    push_frame(0, blank, 8);
    push_frame(1, blank, 8);
    repeat (3) @(negedge clk_in);
    #2;
    run   = 1'b1;
    reset = 1'b1;
    at(66);
    check("busy_end", {7'd0, busy}, 8'h00);
    check("sb_drained2", 8'(sb_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
Downstream display stage for the traffic-light controller. It accepts 8x8 bitmap rows through a simple write port into a back buffer. A commit request swaps the back buffer to the front buffer at the next frame boundary. The front buffer drives the 8x8 LED matrix by row-multiplexed scanning from an internal scan-tick divider, which removes the frame tearing of direct pattern-to-pin driving.

Parameters:
SCAN_DIV, 2500, clk_in cycles per row-scan tick; legal range >= 2; divider counter width is clog2(SCAN_DIV).

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
wr_en  input  1  write one row of the back buffer this cycle
wr_row  input  3  back-buffer row index for the write
wr_data  input  8  row bitmap; bit=1 means LED on
commit  input  1  single-cycle request to publish the back buffer at the next frame start
busy  output  1  commit pending; writes and commits are ignored while high
dot_row  output  8  active-low one-hot row select; row r drives bit (7-r) low
dot_col  output  8  active-high column data for the selected row
frame_start  output  1  one-cycle pulse on the tick that displays row 0

Behaviour:
- Reset (async, reset=0):
  - divider=0, row pointer=0, buffer select=0, pending=0.
  - Both 8x8 buffers are all-zero.
  - dot_row=8'hFF (all rows off), dot_col=8'h00, frame_start=0, busy=0.
  - Asserting reset mid-frame or mid-commit discards all of this state immediately.
- Divider:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick=1 in the cycle where the count equals SCAN_DIV-1.
  - The first tick after reset release occurs in the SCAN_DIV-th clk_in edge.
- On each tick, with row pointer p:
  - dot_row <= ~(8'b1000_0000 >> p).
  - dot_col <= front[p].
  - p <= p+1, wrapping 7->0.
  - frame_start <= (p==0); it is 0 on all other cycles.
  - Row sequence: 01111111, 10111111, ..., 11111110, then wrap to 01111111.
- Outputs are registered and change only on tick edges (or on reset).
- Write port:
  - If wr_en=1 and busy=0, back[wr_row] <= wr_data on that edge.
  - If busy=1, the write is dropped silently.
  - Writes never touch the front buffer.
- Commit:
  - commit=1 with busy=0 sets pending (busy=1 next cycle).
  - commit=1 with busy=1 has no effect.
  - wr_en and commit in the same cycle: the write is applied and belongs to the committed frame.
- Swap:
  - Occurs on a tick with p==0 and pending=1: buffer select toggles and pending clears in the same edge.
  - The row-0 output of that same tick already uses the new front buffer, so a frame is never mixed.
  - Commit-to-display latency is at most 8*SCAN_DIV cycles.
  - If commit is accepted on the same edge as a p==0 tick, the swap waits for the next p==0 tick.
- After a swap, the back buffer holds the previously displayed frame. The writer must rewrite any rows it wants changed.
- States (pending flag): IDLE (busy=0) -> on commit -> PENDING (busy=1) -> on tick with p==0 -> IDLE.

Decomposition:
- Shared package (display_pkg):
  - ROWS=8.
  - Row-select encode function: active-low one-hot from a 3-bit index.
  - Reset constants: ROW_OFF=8'hFF, COL_OFF=8'h00.
  - Default scan divider 2500.
- One sub-module: scan_tick_gen (parameter SCAN_DIV; ports clk_in, reset, tick). This is the divider, reusable by the seven-segment digit multiplexer.
- The buffers are plain register arrays inside dot_matrix_scanner.

Test Plan:
All scenarios run with SCAN_DIV=4.
- Reset then release -> dot_row=8'hFF and dot_col=8'h00 until edge 4; at edge 4, dot_row=8'b01111111, dot_col=8'h00, frame_start=1 for one cycle.
- Write rows 0..7 = 18,18,3C,3C,5A,18,18,24, then commit -> busy=1 until the next frame_start. That frame shows row0 col=8'h18, row4 col=8'h5A, row7 col=8'h24 with dot_row=8'b11111110. busy=0 afterwards.
- While busy=1, write row 2 = 8'hFF and issue a second commit -> no effect; after the swap, the row-2 display stays 8'h3C and busy=0.
- Same-cycle wr_en (row 3 = 8'h7E) and commit on an idle scanner -> the next frame shows row 3 col=8'h7E.
- Run 20 ticks -> row sequence wraps 11111110 -> 01111111, with frame_start exactly on every 8th tick (every 32 clk_in cycles).
- Pull reset low mid-frame with a commit pending -> immediately dot_row=8'hFF, dot_col=0, busy=0. After release, the displayed columns are all 0, confirming the pending frame was discarded.
